draw_sprite_multi: RTL

//  Multi-slot animated sprite overlay in the VGA pipeline (vga_if in -> out).

---
 rtl/draw_sprite_multi_if.sv | 18 +
 rtl/draw_sprite_multi.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/draw_sprite_multi_if.sv
// vga_if: VGA pixel-stream bundle passed between overlay stages.
//   hcount, vcount : 12-bit raster position of the current pixel
//   hsync, vsync   : sync pulses
//   hblnk, vblnk   : blanking flags
//   rgb            : 12-bit colour {r[3:0], g[3:0], b[3:0]}
// Modport "in" is for a consumer of the stream and "out" is for a producer.
interface vga_if;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprite_multi.sv
// draw_sprite_multi: overlays NUM_SPRITES animated rectangular sprites on a
// VGA pixel stream. The output is the input stream delayed by 2 clocks. The rgb
// is replaced by the highest-priority visible sprite pixel, where slot 0 has
// the highest priority.
// Ports:
//   clk60MHz   pixel clock
//   rst_n      synchronous reset, active low
//   sprite_en  per-slot draw enable, latched at vblank start
//   anim_en    1 = step the animation frame every FRAME_DIV vblank starts
//   xpos/ypos  slot i position in bits [12i+:12], latched at vblank start
//   rgb_pixel  per-slot ROM data, 1 clock after pixel_addr
//   pixel_addr per-slot ROM address {frame, addry, addrx}
//   frame_idx  current animation frame
//   in / out   upstream / downstream VGA stream
module draw_sprite_multi #(
    parameter int          NUM_SPRITES = 2,
    parameter int          SPR_AW_X    = 6,
    parameter int          SPR_AW_Y    = 6,
    parameter int          FRAME_BITS  = 1,
    parameter int          FRAME_DIV   = 8,
    parameter logic [11:0] TRANSP_KEY  = 12'hF0F,
    localparam int         AW          = FRAME_BITS + SPR_AW_Y + SPR_AW_X
) (
    input  logic                      clk60MHz,
    input  logic                      rst_n,
    input  logic [NUM_SPRITES-1:0]    sprite_en,
    input  logic                      anim_en,
    input  logic [NUM_SPRITES*12-1:0] xpos,
    input  logic [NUM_SPRITES*12-1:0] ypos,
    input  logic [NUM_SPRITES*12-1:0] rgb_pixel,
    output logic [NUM_SPRITES*AW-1:0] pixel_addr,
    output logic [FRAME_BITS-1:0]     frame_idx,
    vga_if.in                         in,
    vga_if.out                        out
);

    localparam int          DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [12:0] SPR_W    = 13'(2 ** SPR_AW_X);
    localparam logic [12:0] SPR_H    = 13'(2 ** SPR_AW_Y);

    // Shadow copies of the slot positions and enables, held for a whole frame
    logic [11:0]            sx [NUM_SPRITES];
    logic [11:0]            sy [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] en;

    logic                   vblnk_prev;
    logic                   vblank_rise;
    logic [DIV_W-1:0]       divider;

    logic [11:0]            addrx [NUM_SPRITES];
    logic [11:0]            addry [NUM_SPRITES];

    logic [11:0]            hcount_p1;
    logic [11:0]            vcount_p1;
    logic                   hsync_p1;
    logic                   vsync_p1;
    logic                   hblnk_p1;
    logic                   vblnk_p1;
    logic [11:0]            rgb_p1;

    logic [NUM_SPRITES-1:0] hit;
    logic [11:0]            rgb_mix;

    assign vblank_rise = in.vblnk && !vblnk_prev;

    // Shadow latch and animation counter, both updated only at vblank start
    always_ff @(posedge clk60MHz) begin
        if (!rst_n) begin
            vblnk_prev <= 1'b0;
            en         <= '0;
            divider    <= '0;
            frame_idx  <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sx[i] <= '0;
                sy[i] <= '0;
            end
        end else begin
            vblnk_prev <= in.vblnk;
            if (vblank_rise) begin
                en <= sprite_en;
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    sx[i] <= xpos[12*i +: 12];
                    sy[i] <= ypos[12*i +: 12];
                end
                if (!anim_en) begin
                    divider <= '0;
                end else if (divider == DIV_LAST) begin
                    divider   <= '0;
                    frame_idx <= frame_idx + 1'b1;
                end else begin
                    divider <= divider + 1'b1;
                end
            end
        end
    end

    // Stage 0: ROM addresses, relative to each slot origin
    always_comb begin
        pixel_addr = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            addrx[i] = in.hcount - sx[i];
            addry[i] = in.vcount - sy[i];
            pixel_addr[AW*i +: AW] = {frame_idx, addry[i][SPR_AW_Y-1:0],
                                      addrx[i][SPR_AW_X-1:0]};
        end
    end

    // Stage 1: timing and rgb registered to align with the ROM data
    always_ff @(posedge clk60MHz) begin
        if (!rst_n) begin
            hcount_p1 <= '0;
            vcount_p1 <= '0;
            hsync_p1  <= 1'b0;
            vsync_p1  <= 1'b0;
            hblnk_p1  <= 1'b0;
            vblnk_p1  <= 1'b0;
            rgb_p1    <= '0;
        end else begin
            hcount_p1 <= in.hcount;
            vcount_p1 <= in.vcount;
            hsync_p1  <= in.hsync;
            vsync_p1  <= in.vsync;
            hblnk_p1  <= in.hblnk;
            vblnk_p1  <= in.vblnk;
            rgb_p1    <= in.rgb;
        end
    end

    // The compares are 13 bits wide, so a sprite near the right or bottom edge
    // is clipped and does not wrap to column or row 0.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit[i] = en[i]
                && ({1'b0, hcount_p1} >= {1'b0, sx[i]})
                && ({1'b0, hcount_p1} <  ({1'b0, sx[i]} + SPR_W))
                && ({1'b0, vcount_p1} >= {1'b0, sy[i]})
                && ({1'b0, vcount_p1} <  ({1'b0, sy[i]} + SPR_H))
                && (rgb_pixel[12*i +: 12] != TRANSP_KEY);
        end
    end

    // Scan from lowest to highest priority so that slot 0 is applied last
    always_comb begin
        rgb_mix = rgb_p1;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                rgb_mix = rgb_pixel[12*i +: 12];
            end
        end
        if (hblnk_p1 || vblnk_p1) begin
            rgb_mix = rgb_p1;
        end
    end

    // Stage 2: output register
    always_ff @(posedge clk60MHz) begin
        if (!rst_n) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= hcount_p1;
            out.vcount <= vcount_p1;
            out.hsync  <= hsync_p1;
            out.vsync  <= vsync_p1;
            out.hblnk  <= hblnk_p1;
            out.vblnk  <= vblnk_p1;
            out.rgb    <= rgb_mix;
        end
    end

endmodule
